_decoder_pipe: RTL and testbench

Pipelined, flow-controlled n-to-m decoder: the registered, handshaked successor of the combinational one-hot decoder in the utils library. It accepts an N-bit index per transfer and produces an M-bit one-hot or thermometer word one cycle later. Out-of-range indices produce an all-zero word plus an error flag. It sits between producer and consumer stages, for example register-file write-enable and bus-select generation, where either side may stall.

---
 rtl/_decoder_pipe_if.sv | 26 ++
 rtl/_decoder_pipe.sv | 109 ++++++++++
 tb/tb__decoder_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/_decoder_pipe_if.sv
// Handshake bundle for _decoder_pipe: producer side (in_valid/in_ready/in/mode)
// and consumer side (out_valid/out_ready/out/out_err) in one interface.
// master = the environment around the decoder, slave = the decoder itself.
interface _decoder_pipe_if #(
    parameter int N = 5,
    parameter int M = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out;
    logic         out_err;

    modport master (
        output in_valid, in, mode, out_ready,
        input  in_ready, out_valid, out, out_err
    );

    modport slave (
        input  in_valid, in, mode, out_ready,
        output in_ready, out_valid, out, out_err
    );
endinterface

// File: rtl/_decoder_pipe.sv
// _decoder_pipe: registered, flow-controlled N-to-M decoder (one-hot or
// thermometer) with an output register plus one skid register.
// Optional feature macro: DECODER_PIPE_ERRCNT_EN adds a saturating 8-bit
// count of accepted out-of-range indices on port err_count.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side; valid never depends on ready, and in_ready comes
// only from the skid register's valid bit (plus reset), never from out_ready.
module _decoder_pipe #(
    parameter int N = 5,
    parameter int M = 32
) (
    input  logic               clk,
    input  logic               rst,
    _decoder_pipe_if.slave     bus
`ifdef DECODER_PIPE_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);
    // Index is widened so that comparing against M never wraps when M == 2**N.
    localparam int CMP_W = $clog2(M) + 1;
    localparam int W     = (N > CMP_W) ? N : CMP_W;
    localparam logic [W-1:0] M_W = W'(M);

    logic [W-1:0] w_idx;
    logic [M-1:0] w_word;
    logic         w_err;
    logic         w_acc;
    logic         w_drn;

    logic [M-1:0] r_o_word;
    logic         r_o_err;
    logic         r_o_valid;
    logic [M-1:0] r_s_word;
    logic         r_s_err;
    logic         r_s_valid;

    assign w_idx = W'(bus.in);

    // Decode the presented index: one-hot (mode 0) or thermometer (mode 1),
    // forced to zero with the error flag when the index is out of range.
    always_comb begin
        w_err  = (w_idx >= M_W);
        w_word = '0;
        for (int i = 0; i < M; i++) begin
            if (!w_err) begin
                if (bus.mode) begin
                    w_word[i] = (w_idx >= W'(i));
                end else begin
                    w_word[i] = (w_idx == W'(i));
                end
            end
        end
    end

    assign bus.in_ready  = !r_s_valid && !rst;
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign w_drn         = r_o_valid && bus.out_ready;

    assign bus.out_valid = r_o_valid;
    assign bus.out       = r_o_word;
    assign bus.out_err   = r_o_err;

    // Output/skid register update: fill O when it is free or draining,
    // otherwise park in S; on a drain, S refills O before O goes empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_word  <= '0;
            r_o_err   <= 1'b0;
            r_o_valid <= 1'b0;
            r_s_word  <= '0;
            r_s_err   <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            if (w_acc && (!r_o_valid || w_drn)) begin
                // S is necessarily empty here because w_acc requires in_ready.
                r_o_word  <= w_word;
                r_o_err   <= w_err;
                r_o_valid <= 1'b1;
            end else if (w_acc) begin
                r_s_word  <= w_word;
                r_s_err   <= w_err;
                r_s_valid <= 1'b1;
            end else if (w_drn && r_s_valid) begin
                r_o_word  <= r_s_word;
                r_o_err   <= r_s_err;
                r_s_valid <= 1'b0;
            end else if (w_drn) begin
                r_o_valid <= 1'b0;
            end
        end
    end

`ifdef DECODER_PIPE_ERRCNT_EN
    logic [7:0] r_err_count;

    // Count accepted out-of-range indices, sticking at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_acc && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif
endmodule

// File: tb/tb__decoder_pipe.sv
// Bench for _decoder_pipe: three instances (N=5/M=32, N=3/M=6, N=3/M=8)
// driven from directed vector tables and a few hand-written sequences.
module tb__decoder_pipe;
    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    _decoder_pipe_if #(.N(5), .M(32)) ifa ();
    _decoder_pipe_if #(.N(3), .M(6))  ifb ();
    _decoder_pipe_if #(.N(3), .M(8))  ifc ();

`ifdef DECODER_PIPE_ERRCNT_EN
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
    logic [7:0] c_cnt;
`endif

    _decoder_pipe #(.N(5), .M(32)) u_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifa.slave)
`ifdef DECODER_PIPE_ERRCNT_EN
        ,
        .err_count (a_cnt)
`endif
    );

    _decoder_pipe #(.N(3), .M(6)) u_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifb.slave)
`ifdef DECODER_PIPE_ERRCNT_EN
        ,
        .err_count (b_cnt)
`endif
    );

    _decoder_pipe #(.N(3), .M(8)) u_c (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave)
`ifdef DECODER_PIPE_ERRCNT_EN
        ,
        .err_count (c_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic        mode;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t va[8];
    vec_t vb[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // N=5, M=32 vectors: {index, mode, expected word, expected err}
        va[0] = '{5'd7,  1'b0, 32'h0000_0080, 1'b0};
        va[1] = '{5'd3,  1'b1, 32'h0000_000F, 1'b0};
        va[2] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0};
        va[3] = '{5'd0,  1'b0, 32'h0000_0001, 1'b0};
        va[4] = '{5'd0,  1'b1, 32'h0000_0001, 1'b0};
        va[5] = '{5'd31, 1'b0, 32'h8000_0000, 1'b0};
        va[6] = '{5'd16, 1'b1, 32'h0001_FFFF, 1'b0};
        va[7] = '{5'd5,  1'b0, 32'h0000_0020, 1'b0};

        // N=3, M=6 vectors, including both out-of-range indices
        vb[0] = '{5'd6, 1'b0, 32'h0000_0000, 1'b1};
        vb[1] = '{5'd7, 1'b1, 32'h0000_0000, 1'b1};
        vb[2] = '{5'd5, 1'b1, 32'h0000_003F, 1'b0};
        vb[3] = '{5'd2, 1'b0, 32'h0000_0004, 1'b0};
        vb[4] = '{5'd0, 1'b1, 32'h0000_0001, 1'b0};
        vb[5] = '{5'd6, 1'b1, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in = '0; ifa.mode = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in = '0; ifb.mode = 1'b0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in = '0; ifc.mode = 1'b0; ifc.out_ready = 1'b0;

        // reset state
        #2;
        check("rst_a_in_ready",  32'(ifa.in_ready), 32'd0);
        check("rst_a_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_a_out",       ifa.out, 32'd0);
        check("rst_c_out_err",   32'(ifc.out_err), 32'd0);
        #10;
        rst = 1'b0;
        #1;
        check("post_rst_a_in_ready", 32'(ifa.in_ready), 32'd1);
        tick();

        // streaming one-hot / thermometer on N=5, M=32
        for (int i = 0; i < 8; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in       = va[i].idx;
            ifa.mode     = va[i].mode;
            check("a_in_ready", 32'(ifa.in_ready), 32'd1);
            tick();
            check("a_out_valid", 32'(ifa.out_valid), 32'd1);
            check("a_out",       ifa.out, va[i].exp_word);
            check("a_out_err",   32'(ifa.out_err), 32'(va[i].exp_err));
        end
        ifa.in_valid = 1'b0;
        tick();
        check("a_drained", 32'(ifa.out_valid), 32'd0);

        // N=3, M=6 with out-of-range indices
        for (int i = 0; i < 6; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in       = vb[i].idx[2:0];
            ifb.mode     = vb[i].mode;
            tick();
            check("b_out_valid", 32'(ifb.out_valid), 32'd1);
            check("b_out",       32'(ifb.out), vb[i].exp_word);
            check("b_out_err",   32'(ifb.out_err), 32'(vb[i].exp_err));
        end
        ifb.in_valid = 1'b0;
        tick();
        check("b_drained", 32'(ifb.out_valid), 32'd0);
`ifdef DECODER_PIPE_ERRCNT_EN
        check("b_err_count_3", 32'(b_cnt), 32'd3);
`endif

        // backpressure on N=3, M=8: two accepted, third held, then in order
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.mode      = 1'b0;
        ifc.in        = 3'd1;
        check("c_ready_1", 32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in = 3'd2;
        check("c_ready_2", 32'(ifc.in_ready), 32'd1);
        check("c_out_1",   32'(ifc.out), 32'h02);
        tick();
        ifc.in = 3'd3;
        check("c_ready_full", 32'(ifc.in_ready), 32'd0);
        check("c_valid_full", 32'(ifc.out_valid), 32'd1);
        tick();
        check("c_stall_out",   32'(ifc.out), 32'h02);
        check("c_stall_ready", 32'(ifc.in_ready), 32'd0);
        ifc.out_ready = 1'b1;
        tick();
        check("c_out_2",       32'(ifc.out), 32'h04);
        check("c_out_2_valid", 32'(ifc.out_valid), 32'd1);
        check("c_ready_again", 32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
        check("c_out_3",       32'(ifc.out), 32'h08);
        check("c_out_3_valid", 32'(ifc.out_valid), 32'd1);
        tick();
        check("c_empty", 32'(ifc.out_valid), 32'd0);

        // saturation of the error counter on N=3, M=6
`ifdef DECODER_PIPE_ERRCNT_EN
        for (int k = 0; k < 300; k++) begin
            ifb.in_valid = 1'b1;
            ifb.in       = (k % 2 == 0) ? 3'd6 : 3'd7;
            ifb.mode     = 1'b0;
            tick();
        end
        check("b_err_count_sat", 32'(b_cnt), 32'd255);
        ifb.in = 3'd1;
        tick();
        ifb.in_valid = 1'b0;
        check("b_in_range_out",   32'(ifb.out), 32'h02);
        check("b_err_count_hold", 32'(b_cnt), 32'd255);
        tick();
`endif

        // asynchronous reset mid-cycle with both entries of C occupied
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in        = 3'd5;
        tick();
        ifc.in = 3'd6;
        tick();
        ifc.in_valid = 1'b0;
        check("c_prerst_valid", 32'(ifc.out_valid), 32'd1);
        check("c_prerst_out",   32'(ifc.out), 32'h20);
        #3;
        rst = 1'b1;
        #1;
        check("c_rst_valid",    32'(ifc.out_valid), 32'd0);
        check("c_rst_out",      32'(ifc.out), 32'd0);
        check("c_rst_err",      32'(ifc.out_err), 32'd0);
        check("c_rst_in_ready", 32'(ifc.in_ready), 32'd0);
`ifdef DECODER_PIPE_ERRCNT_EN
        check("b_rst_err_count", 32'(b_cnt), 32'd0);
`endif
        #2;
        rst = 1'b0;
        #1;
        check("c_post_rst_ready", 32'(ifc.in_ready), 32'd1);
        tick();
        check("c_post_rst_valid", 32'(ifc.out_valid), 32'd0);
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in        = 3'd4;
        tick();
        ifc.in_valid = 1'b0;
        check("c_new_out",   32'(ifc.out), 32'h10);
        check("c_new_valid", 32'(ifc.out_valid), 32'd1);
        tick();
        check("c_no_stale", 32'(ifc.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
